pipe_control: RTL and testbench
===============================

PIPE_CONTROL -- requirements
Module: pipe_control

Parameters
REQ-001 MW, default 9: machine-code width; opcode is instr[MW-1:MW-OPW].
REQ-002 OPW, default 4: opcode width; SHALL be >= 4.
REQ-003 ALUW, default 4: ALUOp width.
REQ-004 FLUSH_CYC, default 1: bubble cycles inserted after a taken branch; range 1..7.
REQ-005 CW, default 8: illegal-opcode counter width.

Interface
REQ-006 Clk  in  1  sole clock, rising edge.
REQ-007 Reset  in  1  asynchronous, active-high.
REQ-008 instr  in  MW  machine code from fetch.
REQ-009 instr_valid  in  1  instr is meaningful this cycle.
REQ-010 branch_taken  in  1  downstream resolved a taken branch this cycle.
REQ-011 Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, Halt  out  1 each  registered control bits.
REQ-012 ALUOp  out  ALUW  registered ALU operation.
REQ-013 RegDst  out  2  registered destination select: 0 reg0, 1 rs, 2 rt.
REQ-014 ctrl_valid  out  1  registered control bundle is a real instruction.
REQ-015 fetch_stall  out  1  fetch SHALL hold PC and instr; combinational from state only.
REQ-016 illegal_cnt  out  CW  saturating count of illegal opcodes decoded.

Function
REQ-017 Decode latency SHALL be 1 cycle: instr accepted at edge N drives outputs after edge N.
REQ-018 Bubble value SHALL be: all 1-bit controls 0, ALUOp=0111, RegDst=0, ctrl_valid=0; Halt per REQ-024.
REQ-019 Decode table: 0000 load (MemtoReg, RegDst=1); 0001 store (MemWrite, RegWrite=0); 0010 xor ALUOp=0001; 0011 bne (ALUOp=0010, Branch, RegWrite=0); 0100 add 0011; 0101 mv (0110, RegDst=2); 0110 lshift (0100, ALUSrc, RegDst=1); 0111 rshift (0101, ALUSrc, RegDst=1); 1000 loadi (0111, ALUSrc, RegDst=1); 1001 pari (1000, RegDst=2); 1010 halt; 1011 or 1010; 1100 sub 1011; 1101 lsr (0100, RegDst=1); 1110 rsr (0101, RegDst=1).
REQ-020 Unlisted fields SHALL take defaults: RegWrite=1, others 0, ALUOp=0111, RegDst=0; every opcode SHALL fully assign every output (no latches; Halt defaults 0).
REQ-021 Opcode 1111 and any opcode with bits above the low 4 nonzero SHALL be illegal: bubble issued, illegal_cnt +1, saturating at 2^CW-1.
REQ-022 States: RUN, LDSTALL, FLUSH, HALTED; reset state RUN.
REQ-023 RUN: instr_valid=0 -> bubble, stay RUN; valid load -> issue load, go LDSTALL; valid halt -> issue Halt=1 with RegWrite=0, go HALTED; other valid -> issue, stay RUN.
REQ-024 HALTED: Halt held 1, all other outputs bubble, instr ignored; exit only by Reset.
REQ-025 LDSTALL: exactly one cycle; fetch_stall=1, bubble issued, instr ignored, then RUN.
REQ-026 branch_taken=1 in RUN/LDSTALL/FLUSH: next issued value is bubble, state FLUSH, flush counter loaded to FLUSH_CYC-1; branch_taken has priority over load, halt, and LDSTALL.
REQ-027 FLUSH: bubble each cycle, instr ignored, counter decrements; leave to RUN when counter is 0 and branch_taken=0; branch_taken during FLUSH reloads the counter.
REQ-028 branch_taken in HALTED SHALL be ignored.
REQ-029 Illegal opcodes arriving in LDSTALL, FLUSH, HALTED or with instr_valid=0 SHALL NOT count.

Reset
REQ-030 Reset high SHALL immediately force state RUN, all registered outputs to bubble, Halt=0, illegal_cnt=0, flush counter 0, fetch_stall=0, regardless of Clk, including mid-stall/flush/halt.
REQ-031 First instr accepted SHALL be the one valid at the first rising edge after Reset falls.

Verification
REQ-032 instr=0100_xxxxx valid, RUN -> next cycle ALUOp=0011, RegWrite=1, ctrl_valid=1, fetch_stall=0.
REQ-033 load then add back-to-back -> load issued, then 1 cycle fetch_stall=1 with bubble, then add issued with held instr.
REQ-034 FLUSH_CYC=2, branch_taken pulsed with valid add -> 2 bubble cycles, add not issued, then RUN decodes.
REQ-035 halt opcode 1010 -> Halt=1 persists with later valid instrs and branch_taken; Reset asserted mid-cycle -> Halt=0 asynchronously.
REQ-036 CW=2, five illegal 1111 instrs -> illegal_cnt 1,2,3,3,3; all bubbles, RegWrite=0.

Source files
------------

// File: rtl/pipe_control_if.sv
// Handshake/bus bundle between fetch, pipe_control and the datapath.
// The master modport is the fetch/datapath side; the slave modport is the control unit.
interface pipe_control_if #(
  parameter int MW   = 9,
  parameter int ALUW = 4,
  parameter int CW   = 8
);
  logic [MW-1:0]   instr;
  logic            instr_valid;
  logic            branch_taken;
  logic            Branch;
  logic            MemtoReg;
  logic            MemWrite;
  logic            ALUSrc;
  logic            RegWrite;
  logic            Halt;
  logic [ALUW-1:0] ALUOp;
  logic [1:0]      RegDst;
  logic            ctrl_valid;
  logic            fetch_stall;
  logic [CW-1:0]   illegal_cnt;

  modport master (
    output instr, instr_valid, branch_taken,
    input  Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, Halt,
    input  ALUOp, RegDst, ctrl_valid, fetch_stall, illegal_cnt
  );

  modport slave (
    input  instr, instr_valid, branch_taken,
    output Branch, MemtoReg, MemWrite, ALUSrc, RegWrite, Halt,
    output ALUOp, RegDst, ctrl_valid, fetch_stall, illegal_cnt
  );
endinterface

// File: rtl/pipe_control.sv
// Registered control decoder for a short in-order pipeline, with a one-cycle
// load-use stall, a branch flush window, a sticky halt and an illegal-opcode counter.
module pipe_control #(
  parameter int MW        = 9,
  parameter int OPW       = 4,
  parameter int ALUW      = 4,
  parameter int FLUSH_CYC = 1,
  parameter int CW        = 8
) (
  input logic           Clk,
  input logic           Reset,
  pipe_control_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FLUSH   = 2'd2,
    HALTED  = 2'd3
  } state_t;

  typedef struct packed {
    logic            branch;
    logic            memtoreg;
    logic            memwrite;
    logic            alusrc;
    logic            regwrite;
    logic            halt;
    logic [ALUW-1:0] aluop;
    logic [1:0]      regdst;
    logic            valid;
  } ctrl_t;

  localparam logic [3:0]    OP_LOAD    = 4'h0;
  localparam logic [3:0]    OP_HALT    = 4'hA;
  localparam logic [2:0]    FLUSH_LOAD = 3'(FLUSH_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

  function automatic ctrl_t bubble(input logic halt);
    ctrl_t c;
    c       = '0;
    c.aluop = ALUW'(4'b0111);
    c.halt  = halt;
    return c;
  endfunction

  function automatic ctrl_t decode(input logic [3:0] op);
    ctrl_t c;
    c          = bubble(1'b0);
    c.regwrite = 1'b1;
    c.valid    = 1'b1;
    case (op)
      4'h0: begin c.memtoreg = 1'b1; c.regdst = 2'd1; end
      4'h1: begin c.memwrite = 1'b1; c.regwrite = 1'b0; end
      4'h2: c.aluop = ALUW'(4'b0001);
      4'h3: begin c.aluop = ALUW'(4'b0010); c.branch = 1'b1; c.regwrite = 1'b0; end
      4'h4: c.aluop = ALUW'(4'b0011);
      4'h5: begin c.aluop = ALUW'(4'b0110); c.regdst = 2'd2; end
      4'h6: begin c.aluop = ALUW'(4'b0100); c.alusrc = 1'b1; c.regdst = 2'd1; end
      4'h7: begin c.aluop = ALUW'(4'b0101); c.alusrc = 1'b1; c.regdst = 2'd1; end
      4'h8: begin c.alusrc = 1'b1; c.regdst = 2'd1; end
      4'h9: begin c.aluop = ALUW'(4'b1000); c.regdst = 2'd2; end
      4'hA: begin c.halt = 1'b1; c.regwrite = 1'b0; end
      4'hB: c.aluop = ALUW'(4'b1010);
      4'hC: c.aluop = ALUW'(4'b1011);
      4'hD: begin c.aluop = ALUW'(4'b0100); c.regdst = 2'd1; end
      4'hE: begin c.aluop = ALUW'(4'b0101); c.regdst = 2'd1; end
      default: c = bubble(1'b0);
    endcase
    return c;
  endfunction

  state_t         state_q, state_d;
  ctrl_t          ctrl_q, ctrl_d;
  logic [2:0]     flush_cnt_q, flush_cnt_d;
  logic [CW-1:0]  illegal_cnt_q, illegal_cnt_d;
  logic [OPW-1:0] opcode;
  logic           op_illegal;

  assign opcode     = bus.instr[MW-1 -: OPW];
  assign op_illegal = (opcode[3:0] == 4'hF) || ((opcode >> 3'd4) != {OPW{1'b0}});

  always_comb begin
    state_d       = state_q;
    ctrl_d        = bubble(1'b0);
    flush_cnt_d   = flush_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if (state_q == HALTED) begin
      ctrl_d = bubble(1'b1);
    end else if (bus.branch_taken) begin
      // The instruction in the branch slot is squashed, then FLUSH_CYC cycles are spent in FLUSH.
      state_d     = FLUSH;
      flush_cnt_d = FLUSH_LOAD;
    end else begin
      case (state_q)
        RUN: begin
          if (!bus.instr_valid) begin
            state_d = RUN;
          end else if (op_illegal) begin
            if (illegal_cnt_q != CNT_MAX) begin
              illegal_cnt_d = illegal_cnt_q + CW'(1);
            end else begin
              illegal_cnt_d = illegal_cnt_q;
            end
          end else begin
            ctrl_d = decode(opcode[3:0]);
            if (opcode[3:0] == OP_LOAD) begin
              state_d = LDSTALL;
            end else if (opcode[3:0] == OP_HALT) begin
              state_d = HALTED;
            end else begin
              state_d = RUN;
            end
          end
        end
        LDSTALL: state_d = RUN;
        FLUSH: begin
          if (flush_cnt_q == 3'd0) begin
            state_d = RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= RUN;
      ctrl_q        <= bubble(1'b0);
      flush_cnt_q   <= 3'd0;
      illegal_cnt_q <= {CW{1'b0}};
    end else begin
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
      flush_cnt_q   <= flush_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign bus.Branch      = ctrl_q.branch;
  assign bus.MemtoReg    = ctrl_q.memtoreg;
  assign bus.MemWrite    = ctrl_q.memwrite;
  assign bus.ALUSrc      = ctrl_q.alusrc;
  assign bus.RegWrite    = ctrl_q.regwrite;
  assign bus.Halt        = ctrl_q.halt;
  assign bus.ALUOp       = ctrl_q.aluop;
  assign bus.RegDst      = ctrl_q.regdst;
  assign bus.ctrl_valid  = ctrl_q.valid;
  assign bus.fetch_stall = (state_q == LDSTALL);
  assign bus.illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_pipe_control.sv
// Directed and randomized checks of pipe_control against a table-driven
// reference model of the decode, stall, flush, halt and illegal-count rules.
module tb_pipe_control;
  localparam int MW        = 9;
  localparam int OPW       = 4;
  localparam int ALUW      = 4;
  localparam int FLUSH_CYC = 2;
  localparam int CW        = 2;
  localparam int CNT_MAX   = (1 << CW) - 1;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  pipe_control_if #(.MW(MW), .ALUW(ALUW), .CW(CW)) bus ();

  pipe_control #(
    .MW(MW), .OPW(OPW), .ALUW(ALUW), .FLUSH_CYC(FLUSH_CYC), .CW(CW)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Per-opcode reference tables (opcodes 0..14).
  int        alu_tbl [15] = '{7, 7, 1, 2, 3, 6, 4, 5, 7, 8, 7, 10, 11, 4, 5};
  int        dst_tbl [15] = '{1, 0, 0, 0, 0, 2, 1, 1, 1, 2, 0, 0, 0, 1, 1};
  bit [15:0] no_regwrite  = 16'h040A;
  bit [15:0] uses_imm     = 16'h01C0;
  int        sat_seq [5]  = '{1, 2, 3, 3, 3};

  bit m_halted, m_ldstall;
  int m_flush_left, m_cnt;
  bit e_branch, e_memtoreg, e_memwrite, e_alusrc, e_regwrite, e_halt, e_valid;
  int e_aluop, e_regdst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_bubble(input bit h);
    e_branch = 1'b0; e_memtoreg = 1'b0; e_memwrite = 1'b0; e_alusrc = 1'b0;
    e_regwrite = 1'b0; e_valid = 1'b0; e_halt = h;
    e_aluop = 7; e_regdst = 0;
  endtask

  task automatic model_reset();
    m_halted = 1'b0; m_ldstall = 1'b0; m_flush_left = 0; m_cnt = 0;
    model_bubble(1'b0);
  endtask

  // One rising edge of the reference pipeline controller.
  task automatic model_edge();
    int op;
    op = int'(bus.instr[MW-1 -: OPW]);
    model_bubble(m_halted);
    if (!m_halted) begin
      if (bus.branch_taken) begin
        m_flush_left = FLUSH_CYC;
        m_ldstall    = 1'b0;
      end else if (m_ldstall) begin
        m_ldstall = 1'b0;
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (bus.instr_valid) begin
        if (op == 15) begin
          if (m_cnt < CNT_MAX) m_cnt++;
        end else begin
          e_aluop    = alu_tbl[op];
          e_regdst   = dst_tbl[op];
          e_regwrite = !no_regwrite[op];
          e_alusrc   = uses_imm[op];
          e_memtoreg = (op == 0);
          e_memwrite = (op == 1);
          e_branch   = (op == 3);
          e_halt     = (op == 10);
          e_valid    = 1'b1;
          m_ldstall  = (op == 0);
          m_halted   = (op == 10);
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] got_b, exp_b;
    got_b = 32'({bus.Branch, bus.MemtoReg, bus.MemWrite, bus.ALUSrc, bus.RegWrite,
                 bus.Halt, bus.ALUOp, bus.RegDst, bus.ctrl_valid});
    exp_b = 32'({e_branch, e_memtoreg, e_memwrite, e_alusrc, e_regwrite,
                 e_halt, e_aluop[3:0], e_regdst[1:0], e_valid});
    chk({tag, "/ctrl"}, got_b, exp_b);
    chk({tag, "/fetch_stall"}, 32'(bus.fetch_stall), 32'(m_ldstall));
    chk({tag, "/illegal_cnt"}, 32'(bus.illegal_cnt), 32'(m_cnt));
  endtask

  task automatic drive(input bit valid, input logic [3:0] op, input bit br);
    logic [4:0] low;
    low              = 5'($urandom);
    bus.instr        = {op, low};
    bus.instr_valid  = valid;
    bus.branch_taken = br;
  endtask

  task automatic step(input string tag);
    @(posedge Clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Called 1 time unit after a rising edge: reset pulses mid-cycle, released before the next edge.
  task automatic async_reset(input string tag);
    #3 Reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    chk({tag, "/halt_clear"}, 32'(bus.Halt), 32'd0);
    #2 Reset = 1'b0;
  endtask

  initial begin
    logic [3:0] rop;
    bus.instr = '0; bus.instr_valid = 1'b0; bus.branch_taken = 1'b0;
    model_reset();
    @(posedge Clk); #1; check_all("reset_hold0");
    drive(1'b1, 4'h0, 1'b1);
    @(posedge Clk); #1; check_all("reset_hold1");
    #2 Reset = 1'b0;

    drive(1'b1, 4'h4, 1'b0); step("add");
    chk("add_aluop", 32'(bus.ALUOp), 32'd3);
    chk("add_ctrl_valid", 32'(bus.ctrl_valid), 32'd1);

    drive(1'b1, 4'h0, 1'b0); step("load");
    chk("load_fetch_stall", 32'(bus.fetch_stall), 32'd1);
    drive(1'b1, 4'h4, 1'b0); step("ldstall_bubble");
    chk("ldstall_bubble_valid", 32'(bus.ctrl_valid), 32'd0);
    step("add_after_load");
    chk("add_after_load_aluop", 32'(bus.ALUOp), 32'd3);

    drive(1'b1, 4'h4, 1'b1); step("branch");
    chk("branch_squash", 32'(bus.ctrl_valid), 32'd0);
    bus.branch_taken = 1'b0;
    for (int i = 0; i < 4; i++) step("flush_window");
    chk("after_flush_valid", 32'(bus.ctrl_valid), 32'd1);

    drive(1'b1, 4'hF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step("illegal");
      chk("illegal_sat", 32'(bus.illegal_cnt), 32'(sat_seq[i]));
    end
    drive(1'b0, 4'hF, 1'b0); step("illegal_invalid");

    for (int op = 0; op < 15; op++) begin
      drive(1'b1, 4'(op), 1'b0); step("opcode_sweep");
      if (op == 0) step("opcode_sweep_ldstall");
      if (op == 10) async_reset("sweep_halt_reset");
    end

    drive(1'b1, 4'hA, 1'b0); step("halt");
    chk("halt_set", 32'(bus.Halt), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(i), i[0]); step("halted");
      chk("halt_held", 32'(bus.Halt), 32'd1);
    end
    async_reset("halt_reset");

    for (int seg = 0; seg < 6; seg++) begin
      for (int cyc = 0; cyc < 80; cyc++) begin
        rop = 4'($urandom_range(0, 15));
        if (rop == 4'hA && $urandom_range(0, 7) != 0) rop = 4'h2;
        drive($urandom_range(0, 3) != 0, rop, $urandom_range(0, 9) == 0);
        step("rand");
      end
      async_reset("rand_reset");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
